// File: rtl/reg_chain_rr_scheduler.sv
// ----------------------------------------------------------------------------
// reg_chain_rr_scheduler
//
// Purpose:
//    Shares one DEPTH-stage register chain between REQ_CNT requesters. Each
//    cycle a round-robin arbiter picks at most one requester to enter the
//    head of the chain. Every word is tagged with the index of the requester
//    that issued it. The whole chain advances together under the output
//    valid/ready handshake, so a stall at the output freezes every stage,
//    bubbles included.
//
// Optional feature:
//    REG_CHAIN_RR_SCHEDULER_FLUSH_EN - adds the 'flush' input. A flush
//    clears every stage valid bit and blocks all grants for that cycle. The
//    round-robin pointer keeps its value.
//
// Ports:
//    clk       in   rising-edge clock
//    rst       in   asynchronous, active-high reset
//    req_vld   in   [REQ_CNT]              per-requester valid
//    req_data  in   [REQ_CNT*DATA_WIDTH]   requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//    req_rd    out  [REQ_CNT]              per-requester ready, one-hot or zero
//    o_vld     out                         last stage holds a valid word
//    o_data    out  [DATA_WIDTH]           last stage data
//    o_tag     out  [TAG_WIDTH]            source index of o_data
//    o_rd      in                          downstream ready
//    flush     in                          (flush build only) drop all in-flight words
//    busy      out                         any stage holds a valid word
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// RegChainStage
//
// Purpose:
//    One register of the chain: a valid bit, a data word and a source tag.
//    The synchronous clear drops only the valid bit. The data and tag
//    registers keep their contents because nothing downstream looks at them
//    while valid is low.
//
// Ports:
//    clk, rst   clock and asynchronous active-high reset
//    en_i       load vld_i/data_i/tag_i at the next rising edge
//    clr_i      synchronous clear of the valid bit, wins over en_i
//    vld_i      incoming valid
//    data_i     incoming data word
//    tag_i      incoming source tag
//    vld_o      registered valid
//    data_o     registered data word
//    tag_o      registered source tag
// ----------------------------------------------------------------------------
module RegChainStage #(
   parameter int DATA_WIDTH = 8,
   parameter int TAG_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic                  vld_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [TAG_WIDTH-1:0]  tag_i,
   output logic                  vld_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [TAG_WIDTH-1:0]  tag_o
);

   logic                  vld_q;
   logic                  vld_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [TAG_WIDTH-1:0]  tag_d;

   // Next-state selection. The clear only has to kill the valid bit, so
   // data and tag simply hold during a clear.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      tag_d  = tag_q;
      if (clr_i) begin
         vld_d = 1'b0;
      end else if (en_i) begin
         vld_d  = vld_i;
         data_d = data_i;
         tag_d  = tag_i;
      end
   end

   // Stage registers. Reset clears everything so that the outputs read as
   // zero immediately after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         tag_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         tag_q  <= tag_d;
      end
   end

   assign vld_o  = vld_q;
   assign data_o = data_q;
   assign tag_o  = tag_q;

endmodule

module reg_chain_rr_scheduler #(
   parameter  int DATA_WIDTH = 8,
   parameter  int REQ_CNT    = 2,
   parameter  int DEPTH      = 2,
   localparam int TAG_WIDTH  = (REQ_CNT > 2) ? $clog2(REQ_CNT) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [REQ_CNT-1:0]            req_vld,
   input  logic [REQ_CNT*DATA_WIDTH-1:0] req_data,
   output logic [REQ_CNT-1:0]            req_rd,
   output logic                          o_vld,
   output logic [DATA_WIDTH-1:0]         o_data,
   output logic [TAG_WIDTH-1:0]          o_tag,
   input  logic                          o_rd,
`ifdef REG_CHAIN_RR_SCHEDULER_FLUSH_EN
   input  logic                          flush,
`endif
   output logic                          busy
);

   localparam logic [TAG_WIDTH-1:0] LAST_IDX  = TAG_WIDTH'(REQ_CNT - 1);
   localparam logic [TAG_WIDTH:0]   REQ_CNT_W = (TAG_WIDTH + 1)'(REQ_CNT);

   // Round-robin pointer: the first requester that gets considered.
   logic [TAG_WIDTH-1:0]  ptr_q;
   logic [TAG_WIDTH-1:0]  ptr_d;

   // Arbitration results
   logic [REQ_CNT-1:0]    reqRot;
   logic                  grantValid;
   logic [TAG_WIDTH-1:0]  grantIdx;
   logic [DATA_WIDTH-1:0] grantData;
   logic                  transfer;

   // Chain control and per-stage wiring
   logic                  advance;
   logic                  flushActive;
   logic [DEPTH-1:0]      stgVld;
   logic [DATA_WIDTH-1:0] stgData [DEPTH];
   logic [TAG_WIDTH-1:0]  stgTag  [DEPTH];
   logic [DEPTH-1:0]      inVld;
   logic [DATA_WIDTH-1:0] inData  [DEPTH];
   logic [TAG_WIDTH-1:0]  inTag   [DEPTH];

`ifdef REG_CHAIN_RR_SCHEDULER_FLUSH_EN
   assign flushActive = flush;
`else
   assign flushActive = 1'b0;
`endif

   // The chain moves as one unit. It can move whenever the last stage is
   // empty or its word is being consumed. Holding every stage on a stall
   // keeps bubbles in place, so the latency of each word stays fixed.
   assign advance = ~stgVld[DEPTH-1] | o_rd;

   // Rotate the request vector so that bit 0 is the requester at ptr_q. The
   // lowest set bit of the rotated vector is then the round-robin winner.
   // The winner's offset from ptr_q is added back modulo REQ_CNT.
   always_comb begin
      logic [TAG_WIDTH:0] sum;
      reqRot     = REQ_CNT'({req_vld, req_vld} >> ptr_q);
      grantValid = 1'b0;
      grantIdx   = '0;
      sum        = '0;
      for (int i = 0; i < REQ_CNT; i++) begin
         if (!grantValid && reqRot[i]) begin
            grantValid = 1'b1;
            sum        = {1'b0, ptr_q} + (TAG_WIDTH + 1)'(i);
            if (sum >= REQ_CNT_W) begin
               sum = sum - REQ_CNT_W;
            end
            grantIdx = sum[TAG_WIDTH-1:0];
         end
      end
   end

   // Pick the winner's data word. A constant-index mux avoids a variable
   // part-select on the flat request bus.
   always_comb begin
      grantData = '0;
      for (int k = 0; k < REQ_CNT; k++) begin
         if (grantIdx == TAG_WIDTH'(k)) begin
            grantData = req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The ready goes only to the winner, and only when the head stage can
   // accept a word. It is held low during reset, because the cleared chain
   // would otherwise look ready. It is also held low during a flush, because
   // that cycle's load is discarded.
   always_comb begin
      req_rd = '0;
      for (int k = 0; k < REQ_CNT; k++) begin
         req_rd[k] = grantValid & advance & ~rst & ~flushActive &
                     (grantIdx == TAG_WIDTH'(k));
      end
   end

   assign transfer = |req_rd;

   // The pointer moves past the requester that was just served. If nothing
   // transferred, it stays put. That covers stalls and flushes, so a flush
   // does not disturb fairness.
   always_comb begin
      ptr_d = ptr_q;
      if (transfer) begin
         ptr_d = (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Stage inputs. The head takes the arbitration result. When no request is
   // present, the head loads a bubble. Every other stage takes its
   // predecessor.
   always_comb begin
      inVld     = '0;
      inData[0] = grantData;
      inTag[0]  = grantIdx;
      inVld[0]  = grantValid;
      for (int s = 1; s < DEPTH; s++) begin
         inVld[s]  = stgVld[s-1];
         inData[s] = stgData[s-1];
         inTag[s]  = stgTag[s-1];
      end
   end

   for (genvar s = 0; s < DEPTH; s++) begin : gStage
      RegChainStage #(
         .DATA_WIDTH (DATA_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH)
      ) uStage (
         .clk    (clk),
         .rst    (rst),
         .en_i   (advance),
         .clr_i  (flushActive),
         .vld_i  (inVld[s]),
         .data_i (inData[s]),
         .tag_i  (inTag[s]),
         .vld_o  (stgVld[s]),
         .data_o (stgData[s]),
         .tag_o  (stgTag[s])
      );
   end

   assign o_vld  = stgVld[DEPTH-1];
   assign o_data = stgData[DEPTH-1];
   assign o_tag  = stgTag[DEPTH-1];
   assign busy   = |stgVld;

endmodule
